// File: rtl/read_burst_master.sv
// Word-addressed read burst master with a first-word-fall-through output FIFO.
// Optional abort input enabled by defining READ_BURST_ABORT_EN.
module read_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef READ_BURST_ABORT_EN
    input  logic                  abort_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  m_req_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    input  logic                  m_gnt_i,
    input  logic                  m_rvalid_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   remaining;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_after_pop;

    logic                   abort;
    logic                   push;
    logic                   pop;
    logic                   room;

`ifdef READ_BURST_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // A same-cycle pop frees a slot, so a full FIFO being drained can still accept a beat.
    always_comb begin
        pop             = dout_valid_o && dout_ready_i;
        count_after_pop = count - {{(CNT_W-1){1'b0}}, pop};
        room            = count_after_pop < CNT_W'(FIFO_DEPTH);
        m_req_o         = (state == ISSUE) && room && !abort;
        push            = m_req_o && m_gnt_i && m_rvalid_i;
    end

    assign busy_o       = (state != IDLE);
    assign m_addr_o     = addr;
    assign dout_valid_o = (count != '0);
    assign dout_o       = dout_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        addr      <= base_addr_i;
                        remaining <= len_i;
                        if (len_i == '0)
                            done_o <= 1'b1;
                        else
                            state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state <= DRAIN;
                    end else if (push) begin
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    // Storage carries no reset; dout_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= m_rdata_i;
    end

endmodule

// File: tb/tb_read_burst_master.sv
// Directed bench for read_burst_master: cycle table for a basic burst plus corner-case sequences.
// Read data is modelled as 0xD0000000 | address so order and address errors both show up in dout.
module tb_read_burst_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base = '0;
    logic [7:0]  len = '0;
    logic        busy, done, m_req;
    logic [10:0] m_addr;
    logic        m_gnt = 1'b1;
    logic        m_rvalid = 1'b1;
    logic [31:0] m_rdata;
    logic [31:0] dout;
    logic        dout_valid;
    logic        ready = 1'b1;
    logic        abort = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    logic [10:0] fired_q[$];
    logic [31:0] popped_q[$];
    int n_done = 0, n_req = 0, n_busy = 0;
    int fb, pb, db, rb, bb;

    always #5 clk = ~clk;

    assign m_rdata = 32'hD000_0000 | 32'(m_addr);

    read_burst_master dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .base_addr_i  (base),
        .len_i        (len),
`ifdef READ_BURST_ABORT_EN
        .abort_i      (abort),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .m_req_o      (m_req),
        .m_addr_o     (m_addr),
        .m_gnt_i      (m_gnt),
        .m_rvalid_i   (m_rvalid),
        .m_rdata_i    (m_rdata),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (ready)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (m_req && m_gnt && m_rvalid) fired_q.push_back(m_addr);
            if (dout_valid && ready) popped_q.push_back(dout);
            if (done) n_done++;
            if (m_req) n_req++;
            if (busy) n_busy++;
        end
    end

    typedef struct {
        logic        start;
        logic [10:0] base;
        logic [7:0]  len;
        logic        busy;
        logic        done;
        logic        req;
        logic [10:0] addr;
        logic        dv;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mark();
        fb = fired_q.size();
        pb = popped_q.size();
        db = n_done;
        rb = n_req;
        bb = n_busy;
    endtask

    task automatic start_burst(input logic [10:0] b, input logic [7:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_fired(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fired_q.size() - fb >= n) break;
            @(negedge clk); #1;
        end
        check({name, " beats seen in time"}, 32'(fired_q.size() - fb >= n), 32'd1);
    endtask

    task automatic check_burst(input string name, input logic [10:0] b, input int n);
        logic [10:0] a;
        check({name, " beats issued"}, 32'(fired_q.size() - fb), 32'(n));
        check({name, " beats popped"}, 32'(popped_q.size() - pb), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = b + 11'(i);
            check($sformatf("%s addr[%0d]", name, i),
                  (fb + i < fired_q.size()) ? 32'(fired_q[fb + i]) : 32'hxxxx_xxxx, 32'(a));
            check($sformatf("%s data[%0d]", name, i),
                  (pb + i < popped_q.size()) ? popped_q[pb + i] : 32'hxxxx_xxxx,
                  32'hD000_0000 | 32'(a));
        end
        check({name, " done pulses"}, 32'(n_done - db), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            start base    len  busy done req addr    dv  dout
        tbl[0] = '{1'b1, 11'h100, 8'd3, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 11'h000, 8'd0, 1'b1, 1'b0, 1'b1, 11'h100, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 11'h000, 8'd0, 1'b1, 1'b0, 1'b1, 11'h101, 1'b1, 32'hD000_0100};
        tbl[3] = '{1'b0, 11'h000, 8'd0, 1'b1, 1'b0, 1'b1, 11'h102, 1'b1, 32'hD000_0101};
        tbl[4] = '{1'b0, 11'h000, 8'd0, 1'b1, 1'b0, 1'b0, 11'h103, 1'b1, 32'hD000_0102};
        tbl[5] = '{1'b0, 11'h000, 8'd0, 1'b1, 1'b0, 1'b0, 11'h103, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 11'h000, 8'd0, 1'b0, 1'b1, 1'b0, 11'h103, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 11'h000, 8'd0, 1'b0, 1'b0, 1'b0, 11'h103, 1'b0, 32'h0};

        @(posedge clk); #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset req", 32'(m_req), 32'd0);
        check("reset addr", 32'(m_addr), 32'd0);
        check("reset dout_valid", 32'(dout_valid), 32'd0);
        check("reset dout", dout, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic burst, first start right after reset release
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start;
            base  = tbl[i].base;
            len   = tbl[i].len;
            @(negedge clk);
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("row%0d req", i), 32'(m_req), 32'(tbl[i].req));
            check($sformatf("row%0d addr", i), 32'(m_addr), 32'(tbl[i].addr));
            check($sformatf("row%0d dout_valid", i), 32'(dout_valid), 32'(tbl[i].dv));
            check($sformatf("row%0d dout", i), dout, tbl[i].dout);
            @(posedge clk); #1;
        end

        // Zero length
        mark();
        start = 1'b1; base = 11'h123; len = 8'd0;
        @(negedge clk);
        check("zero busy c0", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero done c1", 32'(done), 32'd1);
        check("zero busy c1", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero done c2", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("zero req count", 32'(n_req - rb), 32'd0);
        check("zero busy count", 32'(n_busy - bb), 32'd0);
        check("zero done count", 32'(n_done - db), 32'd1);

        // Backpressure
        mark();
        ready = 1'b0;
        start_burst(11'h200, 8'd6);
        repeat (10) begin @(posedge clk); #1; end
        check("bp beats while blocked", 32'(fired_q.size() - fb), 32'd4);
        check("bp req dropped", 32'(m_req), 32'd0);
        check("bp dout_valid", 32'(dout_valid), 32'd1);
        check("bp head", dout, 32'hD000_0200);
        ready = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check_burst("bp", 11'h200, 6);
        check("bp idle after", 32'(busy), 32'd0);

        // Wrap with grant stall
        mark();
        m_gnt = 1'b0;
        start_burst(11'h7FE, 8'd3);
        check("stall req c1", 32'(m_req), 32'd1);
        check("stall addr c1", 32'(m_addr), 32'h7FE);
        @(posedge clk); #1;
        check("stall addr c2", 32'(m_addr), 32'h7FE);
        check("stall no beat", 32'(fired_q.size() - fb), 32'd0);
        @(posedge clk); #1;
        m_gnt = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check_burst("wrap", 11'h7FE, 3);

        // Grant without rvalid holds the beat
        mark();
        m_rvalid = 1'b0;
        start_burst(11'h050, 8'd2);
        check("norv addr c1", 32'(m_addr), 32'h050);
        @(posedge clk); #1;
        check("norv addr c2", 32'(m_addr), 32'h050);
        check("norv req c2", 32'(m_req), 32'd1);
        check("norv no beat", 32'(fired_q.size() - fb), 32'd0);
        m_rvalid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_burst("norv", 11'h050, 2);

        // Reset mid-burst
        mark();
        start_burst(11'h300, 8'd5);
        wait_fired("rst", 2, 20);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst req", 32'(m_req), 32'd0);
        check("rst addr", 32'(m_addr), 32'd0);
        check("rst dout_valid", 32'(dout_valid), 32'd0);
        check("rst dout", dout, 32'd0);
        #10;
        @(negedge clk); #1;
        reset = 1'b0;
        mark();
        start_burst(11'h010, 8'd1);
        check("post-rst busy", 32'(busy), 32'd1);
        check("post-rst req", 32'(m_req), 32'd1);
        check("post-rst addr", 32'(m_addr), 32'h010);
        repeat (10) begin @(posedge clk); #1; end
        check_burst("post-rst", 11'h010, 1);

`ifdef READ_BURST_ABORT_EN
        // Abort after three beats
        mark();
        start_burst(11'h400, 8'd8);
        wait_fired("abort", 3, 20);
        @(posedge clk); #1;
        abort = 1'b1;
        check("abort req drop", 32'(m_req), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        check_burst("abort", 11'h400, 3);
        check("abort idle after", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
